csa_resolver: RTL

//  Consumer end of the carry-save datapath: accepts one redundant (sum, carry) vector

---
 rtl/csa_resolver.sv | 104 ++++++++++
 1 files changed

// File: rtl/csa_resolver.sv
// Resolves a carry-save (sum, carry) pair to a binary result with a chunked ripple add.
// The add covers CHUNK bits per cycle, so one operation takes WIDTH/CHUNK cycles.
module csa_resolver #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             busy
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  s_q, k_q, work_q, work_nxt;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic [CHUNK:0]    chunk_add;
    logic              last_chunk;

    assign last_chunk = (idx_q == IDXW'(N - 1));

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        chunk_add = {1'b0, s_q[idx_q*CHUNK +: CHUNK]}
                  + {1'b0, k_q[idx_q*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};
        work_nxt = work_q;
        work_nxt[idx_q*CHUNK +: CHUNK] = chunk_add[CHUNK-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = RUN;
            RUN:     if (last_chunk) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // NOTE: the operand and working registers are reset as well, so a reset in mid-operation leaves no stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q        <= '0;
            k_q        <= '0;
            work_q     <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            out_result <= '0;
            out_cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s_q     <= in_sum;
                        k_q     <= in_carry;
                        work_q  <= '0;
                        idx_q   <= '0;
                        carry_q <= 1'b0;
                    end
                end
                RUN: begin
                    work_q  <= work_nxt;
                    carry_q <= chunk_add[CHUNK];
                    idx_q   <= idx_q + IDXW'(1);
                    if (last_chunk) begin
                        // Results are published only on entry to DONE; they hold until the next completion.
                        out_result <= work_nxt;
                        out_cout   <= chunk_add[CHUNK];
                        idx_q      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule
